tl_source_shrinker: RTL and testbench

//  Sits directly downstream of the TL fragmenter's out port.

---
 rtl/tl_source_shrinker.sv | 142 ++++++++++++++
 tb/tb_tl_source_shrinker.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_source_shrinker.sv
// tl_source_shrinker: maps the wide upstream A-channel source ID onto a small
// pool of slave-side IDs and restores the original source on the D channel.
// Traffic is single-beat: one A fire takes one ID, one D fire returns it.
module tl_source_shrinker #(
    parameter int unsigned IN_SOURCE_W  = 11,
    parameter int unsigned OUT_IDS      = 4,
    parameter int unsigned OUT_SOURCE_W = 2,
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 64
) (
    input  logic                     clock,
    input  logic                     reset,

    // A channel from the fragmenter
    input  logic                     auto_in_a_valid,
    output logic                     auto_in_a_ready,
    input  logic [2:0]               auto_in_a_bits_opcode,
    input  logic [2:0]               auto_in_a_bits_param,
    input  logic [1:0]               auto_in_a_bits_size,
    input  logic [IN_SOURCE_W-1:0]   auto_in_a_bits_source,
    input  logic [ADDR_W-1:0]        auto_in_a_bits_address,
    input  logic [DATA_W/8-1:0]      auto_in_a_bits_mask,
    input  logic [DATA_W-1:0]        auto_in_a_bits_data,
    input  logic                     auto_in_a_bits_corrupt,

    // A channel toward the slave
    output logic                     auto_out_a_valid,
    input  logic                     auto_out_a_ready,
    output logic [2:0]               auto_out_a_bits_opcode,
    output logic [2:0]               auto_out_a_bits_param,
    output logic [1:0]               auto_out_a_bits_size,
    output logic [OUT_SOURCE_W-1:0]  auto_out_a_bits_source,
    output logic [ADDR_W-1:0]        auto_out_a_bits_address,
    output logic [DATA_W/8-1:0]      auto_out_a_bits_mask,
    output logic [DATA_W-1:0]        auto_out_a_bits_data,
    output logic                     auto_out_a_bits_corrupt,

    // D channel from the slave
    input  logic                     auto_out_d_valid,
    output logic                     auto_out_d_ready,
    input  logic [2:0]               auto_out_d_bits_opcode,
    input  logic [1:0]               auto_out_d_bits_size,
    input  logic [OUT_SOURCE_W-1:0]  auto_out_d_bits_source,
    input  logic [DATA_W-1:0]        auto_out_d_bits_data,

    // D channel toward the fragmenter
    output logic                     auto_in_d_valid,
    input  logic                     auto_in_d_ready,
    output logic [2:0]               auto_in_d_bits_opcode,
    output logic [1:0]               auto_in_d_bits_size,
    output logic [IN_SOURCE_W-1:0]   auto_in_d_bits_source,
    output logic [DATA_W-1:0]        auto_in_d_bits_data
);

    localparam int unsigned MASK_W = DATA_W / 8;

    // Slot state: free_q bit set means the slot is idle; tbl_q holds the
    // upstream source of each busy slot (contents of idle slots are don't-care).
    logic [OUT_IDS-1:0]     free_q, free_d;
    logic [IN_SOURCE_W-1:0] tbl_q [OUT_IDS];
    logic [IN_SOURCE_W-1:0] tbl_d [OUT_IDS];

    logic                    any_free;
    logic [OUT_SOURCE_W-1:0] alloc;
    logic                    a_fire;
    logic                    d_fire;

    // Pick the lowest idle slot from the registered vector; a slot freed this
    // cycle only becomes eligible once free_q reflects it.
    always_comb begin
        alloc    = '0;
        any_free = |free_q;
        for (int i = int'(OUT_IDS) - 1; i >= 0; i--) begin
            if (free_q[i]) begin
                alloc = OUT_SOURCE_W'(i);
            end
        end
    end

    // A channel: zero-latency pass-through gated by slot availability and reset.
    always_comb begin
        auto_out_a_valid        = auto_in_a_valid & any_free & ~reset;
        auto_in_a_ready         = auto_out_a_ready & any_free & ~reset;
        auto_out_a_bits_opcode  = auto_in_a_bits_opcode;
        auto_out_a_bits_param   = auto_in_a_bits_param;
        auto_out_a_bits_size    = auto_in_a_bits_size;
        auto_out_a_bits_source  = alloc;
        auto_out_a_bits_address = auto_in_a_bits_address;
        auto_out_a_bits_mask    = MASK_W'(auto_in_a_bits_mask);
        auto_out_a_bits_data    = auto_in_a_bits_data;
        auto_out_a_bits_corrupt = auto_in_a_bits_corrupt;
    end

    // D channel: zero-latency pass-through with the source restored from the table.
    always_comb begin
        auto_in_d_valid       = auto_out_d_valid;
        auto_out_d_ready      = auto_in_d_ready;
        auto_in_d_bits_opcode = auto_out_d_bits_opcode;
        auto_in_d_bits_size   = auto_out_d_bits_size;
        auto_in_d_bits_source = tbl_q[auto_out_d_bits_source];
        auto_in_d_bits_data   = auto_out_d_bits_data;
    end

    assign a_fire = auto_out_a_valid & auto_out_a_ready;
    assign d_fire = auto_out_d_valid & auto_in_d_ready;

    // Next slot state: A fire claims alloc, D fire releases the returned ID.
    // The release is applied last so a bogus D on an idle slot leaves it idle.
    always_comb begin
        free_d = free_q;
        tbl_d  = tbl_q;
        if (a_fire) begin
            free_d[alloc] = 1'b0;
            tbl_d[alloc]  = auto_in_a_bits_source;
        end
        if (d_fire) begin
            free_d[auto_out_d_bits_source] = 1'b1;
        end
    end

    // Free vector register; reset returns every slot to the pool.
    always_ff @(posedge clock) begin
        if (reset) begin
            free_q <= '1;
        end else begin
            free_q <= free_d;
        end
    end

    // Source table register; only meaningful for busy slots, so left unreset.
    always_ff @(posedge clock) begin
        tbl_q <= tbl_d;
    end

    // A response must only ever return an ID that is currently in flight.
    always_ff @(posedge clock) begin
        if (!reset && d_fire) begin
            assert (!free_q[auto_out_d_bits_source]);
        end
    end

endmodule

// File: tb/tb_tl_source_shrinker.sv
// Scoreboard bench for tl_source_shrinker: stimulus pushes expected A/D
// transfers into queues, monitors pop and compare on every handshake.
module tb_tl_source_shrinker;

    localparam int unsigned IN_SOURCE_W  = 11;
    localparam int unsigned OUT_SOURCE_W = 2;
    localparam int unsigned ADDR_W       = 12;
    localparam int unsigned DATA_W       = 64;
    localparam int unsigned MASK_W       = DATA_W / 8;

    typedef struct packed {
        logic [2:0]              opcode;
        logic [2:0]              param;
        logic [1:0]              size;
        logic [OUT_SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]       address;
        logic [MASK_W-1:0]       mask;
        logic [DATA_W-1:0]       data;
        logic                    corrupt;
    } a_exp_t;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [1:0]             size;
        logic [IN_SOURCE_W-1:0] source;
        logic [DATA_W-1:0]      data;
    } d_exp_t;

    logic clock = 1'b0;
    logic reset;

    logic                    in_a_valid, in_a_ready;
    logic [2:0]              in_a_opcode, in_a_param;
    logic [1:0]              in_a_size;
    logic [IN_SOURCE_W-1:0]  in_a_source;
    logic [ADDR_W-1:0]       in_a_address;
    logic [MASK_W-1:0]       in_a_mask;
    logic [DATA_W-1:0]       in_a_data;
    logic                    in_a_corrupt;

    logic                    out_a_valid, out_a_ready;
    logic [2:0]              out_a_opcode, out_a_param;
    logic [1:0]              out_a_size;
    logic [OUT_SOURCE_W-1:0] out_a_source;
    logic [ADDR_W-1:0]       out_a_address;
    logic [MASK_W-1:0]       out_a_mask;
    logic [DATA_W-1:0]       out_a_data;
    logic                    out_a_corrupt;

    logic                    out_d_valid, out_d_ready;
    logic [2:0]              out_d_opcode;
    logic [1:0]              out_d_size;
    logic [OUT_SOURCE_W-1:0] out_d_source;
    logic [DATA_W-1:0]       out_d_data;

    logic                    in_d_valid, in_d_ready;
    logic [2:0]              in_d_opcode;
    logic [1:0]              in_d_size;
    logic [IN_SOURCE_W-1:0]  in_d_source;
    logic [DATA_W-1:0]       in_d_data;

    int total = 0;
    int bad   = 0;

    a_exp_t exp_a_q [$];
    d_exp_t exp_d_q [$];

    tl_source_shrinker dut (
        .clock                   (clock),
        .reset                   (reset),
        .auto_in_a_valid         (in_a_valid),
        .auto_in_a_ready         (in_a_ready),
        .auto_in_a_bits_opcode   (in_a_opcode),
        .auto_in_a_bits_param    (in_a_param),
        .auto_in_a_bits_size     (in_a_size),
        .auto_in_a_bits_source   (in_a_source),
        .auto_in_a_bits_address  (in_a_address),
        .auto_in_a_bits_mask     (in_a_mask),
        .auto_in_a_bits_data     (in_a_data),
        .auto_in_a_bits_corrupt  (in_a_corrupt),
        .auto_out_a_valid        (out_a_valid),
        .auto_out_a_ready        (out_a_ready),
        .auto_out_a_bits_opcode  (out_a_opcode),
        .auto_out_a_bits_param   (out_a_param),
        .auto_out_a_bits_size    (out_a_size),
        .auto_out_a_bits_source  (out_a_source),
        .auto_out_a_bits_address (out_a_address),
        .auto_out_a_bits_mask    (out_a_mask),
        .auto_out_a_bits_data    (out_a_data),
        .auto_out_a_bits_corrupt (out_a_corrupt),
        .auto_out_d_valid        (out_d_valid),
        .auto_out_d_ready        (out_d_ready),
        .auto_out_d_bits_opcode  (out_d_opcode),
        .auto_out_d_bits_size    (out_d_size),
        .auto_out_d_bits_source  (out_d_source),
        .auto_out_d_bits_data    (out_d_data),
        .auto_in_d_valid         (in_d_valid),
        .auto_in_d_ready         (in_d_ready),
        .auto_in_d_bits_opcode   (in_d_opcode),
        .auto_in_d_bits_size     (in_d_size),
        .auto_in_d_bits_source   (in_d_source),
        .auto_in_d_bits_data     (in_d_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Drive an upstream A request; side fields are derived from the source.
    task automatic drive_a(input logic [IN_SOURCE_W-1:0] src);
        in_a_valid   = 1'b1;
        in_a_source  = src;
        in_a_opcode  = 3'(src);
        in_a_param   = 3'(src >> 3);
        in_a_size    = 2'(src >> 6);
        in_a_address = 12'(src * 8);
        in_a_mask    = 8'(src) ^ 8'hA5;
        in_a_data    = {21'(src), 43'h1234_5678_9AB};
        in_a_corrupt = src[0];
    endtask

    task automatic push_a(input logic [IN_SOURCE_W-1:0] src, input logic [OUT_SOURCE_W-1:0] id);
        a_exp_t e;
        e.opcode  = 3'(src);
        e.param   = 3'(src >> 3);
        e.size    = 2'(src >> 6);
        e.source  = id;
        e.address = 12'(src * 8);
        e.mask    = 8'(src) ^ 8'hA5;
        e.data    = {21'(src), 43'h1234_5678_9AB};
        e.corrupt = src[0];
        exp_a_q.push_back(e);
    endtask

    // One accepted A: the request must be ready on its first cycle.
    task automatic send_a(input logic [IN_SOURCE_W-1:0] src, input logic [OUT_SOURCE_W-1:0] id);
        push_a(src, id);
        drive_a(src);
        @(negedge clock);
        chk("a_ready", 64'(in_a_ready), 64'd1);
        cyc();
        in_a_valid = 1'b0;
    endtask

    task automatic drive_d(input logic [OUT_SOURCE_W-1:0] id, input logic [DATA_W-1:0] data);
        out_d_valid  = 1'b1;
        out_d_source = id;
        out_d_data   = data;
        out_d_opcode = 3'd1;
        out_d_size   = 2'd3;
    endtask

    task automatic push_d(input logic [IN_SOURCE_W-1:0] src, input logic [DATA_W-1:0] data);
        d_exp_t e;
        e.opcode = 3'd1;
        e.size   = 2'd3;
        e.source = src;
        e.data   = data;
        exp_d_q.push_back(e);
    endtask

    // One accepted D response returning id, expected to restore src.
    task automatic send_d(input logic [OUT_SOURCE_W-1:0] id, input logic [IN_SOURCE_W-1:0] src,
                          input logic [DATA_W-1:0] data);
        push_d(src, data);
        drive_d(id, data);
        in_d_ready = 1'b1;
        @(negedge clock);
        chk("d_ready", 64'(out_d_ready), 64'd1);
        cyc();
        out_d_valid = 1'b0;
    endtask

    task automatic chk_stalled(input string name);
        chk({name, "_in_a_ready"}, 64'(in_a_ready), 64'd0);
        chk({name, "_out_a_valid"}, 64'(out_a_valid), 64'd0);
    endtask

    // A monitor: every accepted slave-side A must match the next expectation.
    always @(negedge clock) begin
        if (!reset && out_a_valid && out_a_ready) begin
            if (exp_a_q.size() == 0) begin
                chk("a_unexpected", 64'd1, 64'd0);
            end else begin
                a_exp_t e;
                e = exp_a_q.pop_front();
                chk("a_source",  64'(out_a_source),  64'(e.source));
                chk("a_opcode",  64'(out_a_opcode),  64'(e.opcode));
                chk("a_param",   64'(out_a_param),   64'(e.param));
                chk("a_size",    64'(out_a_size),    64'(e.size));
                chk("a_address", 64'(out_a_address), 64'(e.address));
                chk("a_mask",    64'(out_a_mask),    64'(e.mask));
                chk("a_data",    out_a_data,         e.data);
                chk("a_corrupt", 64'(out_a_corrupt), 64'(e.corrupt));
            end
        end
    end

    // D monitor: every accepted upstream D must match the next expectation.
    always @(negedge clock) begin
        if (!reset && in_d_valid && in_d_ready) begin
            if (exp_d_q.size() == 0) begin
                chk("d_unexpected", 64'd1, 64'd0);
            end else begin
                d_exp_t e;
                e = exp_d_q.pop_front();
                chk("d_source", 64'(in_d_source), 64'(e.source));
                chk("d_opcode", 64'(in_d_opcode), 64'(e.opcode));
                chk("d_size",   64'(in_d_size),   64'(e.size));
                chk("d_data",   in_d_data,        e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        out_a_ready = 1'b1;
        in_d_ready  = 1'b1;
        out_d_valid = 1'b0;
        drive_d(2'd0, 64'd0);
        out_d_valid = 1'b0;
        drive_a(11'h5A3);

        // 1: reset gating, then a single Get and its response
        @(negedge clock);
        chk_stalled("reset");
        cyc();
        cyc();
        push_a(11'h5A3, 2'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("t1_a_ready", 64'(in_a_ready), 64'd1);
        cyc();
        in_a_valid = 1'b0;
        send_d(2'd0, 11'h5A3, 64'hDEAD_BEEF_0123_4567);

        // 2: four back-to-back Puts take ids 0..3, 5th stalls
        for (int i = 0; i < 4; i++) begin
            send_a(11'(i + 1), 2'(i));
        end
        drive_a(11'h005);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk_stalled("full");
            cyc();
        end

        // 4: D on id 1 alongside the stalled A; A gets id 1 the cycle after
        push_d(11'h002, 64'h1111_2222_3333_4444);
        drive_d(2'd1, 64'h1111_2222_3333_4444);
        @(negedge clock);
        chk_stalled("simul");
        chk("simul_d_ready", 64'(out_d_ready), 64'd1);
        cyc();
        out_d_valid = 1'b0;
        push_a(11'h005, 2'd1);
        @(negedge clock);
        chk("resume_a_ready", 64'(in_a_ready), 64'd1);
        cyc();
        in_a_valid = 1'b0;

        // 3: out-of-order return 2,0,3,1
        send_d(2'd2, 11'h003, 64'hA0A0_0000_0000_0002);
        send_d(2'd0, 11'h001, 64'hA0A0_0000_0000_0000);
        send_d(2'd3, 11'h004, 64'hA0A0_0000_0000_0003);
        send_d(2'd1, 11'h005, 64'hA0A0_0000_0000_0001);

        // whole pool free again
        for (int i = 0; i < 4; i++) begin
            send_a(11'(16 + i), 2'(i));
        end

        // 5: D backpressure holds the slot busy and the data stable
        drive_a(11'h020);
        drive_d(2'd3, 64'hCAFE_F00D_5555_AAAA);
        in_d_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("bp_out_d_ready", 64'(out_d_ready), 64'd0);
            chk("bp_in_d_valid",  64'(in_d_valid),  64'd1);
            chk("bp_in_d_source", 64'(in_d_source), 64'h013);
            chk("bp_in_d_data",   in_d_data,        64'hCAFE_F00D_5555_AAAA);
            chk_stalled("bp");
            cyc();
        end
        push_d(11'h013, 64'hCAFE_F00D_5555_AAAA);
        in_d_ready = 1'b1;
        @(negedge clock);
        chk_stalled("bp_release");
        cyc();
        out_d_valid = 1'b0;
        push_a(11'h020, 2'd3);
        @(negedge clock);
        chk("bp_resume_ready", 64'(in_a_ready), 64'd1);
        cyc();
        in_a_valid = 1'b0;

        // 6: reset with three slots busy frees everything
        send_d(2'd0, 11'h010, 64'h0);
        drive_a(11'h030);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk_stalled("mid_reset");
            cyc();
        end
        push_a(11'h030, 2'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_ready", 64'(in_a_ready), 64'd1);
        cyc();
        in_a_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            send_a(11'(48 + i), 2'(i));
        end
        drive_a(11'h034);
        @(negedge clock);
        chk_stalled("post_reset_full");
        cyc();
        in_a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_d(2'(i), 11'(48 + i), 64'(i * 7 + 1));
        end

        cyc();
        cyc();
        chk("a_queue_empty", 64'(exp_a_q.size()), 64'd0);
        chk("d_queue_empty", 64'(exp_d_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
